// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiplier datapath.
// Used by the feed controller, the skew registers and the PE array.
//   ctrl_state_t : feed-controller state encoding
//   flush_len    : cycles needed to drain the skew pipeline and PE latency
//   cnt_width    : bits for a counter that must hold 0..max_val
//   addr_width   : bits to address depth entries
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } ctrl_state_t;

    function automatic int flush_len(input int n, input int pe_lat);
        return 2 * (n - 1) + pe_lat;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_step_counter.sv
// step_counter: loadable up-counter with synchronous clear and a terminal-count
// flag that compares against a run-time limit.
//   clk, reset : clock, synchronous active-high reset
//   clr        : return count to zero (wins over ld/en)
//   ld, ld_val : load an arbitrary start value
//   en         : advance by one
//   limit      : terminal value
//   count      : current value
//   tc         : count == limit
module step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one tile product of the N x N systolic array.
// Clears the skew registers and accumulators, streams K operand beats, drains
// the pipeline, then pulses done. Every output is registered.
//   clk, reset : clock, synchronous active-high reset
//   start      : job request (accepted in IDLE or DONE)
//   k_len      : inner dimension, clamped to K_MAX when latched
//   hold       : stall FEED/FLUSH progress
//   abort      : cancel a running job
//   sr_clear   : skew-register sync reset
//   shift      : skew-register shift enable
//   feed_valid : 1 = buffer data, 0 = inject zeros
//   k_idx      : A column / B row read address
//   acc_clear  : accumulator clear
//   acc_en     : accumulate enable
//   busy       : job in progress
//   done       : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle: clear skew registers and accumulators
// FEED  | stream K operand beats, one per non-held cycle
// FLUSH | shift zeros until the last product has reached the accumulators
// DONE  | completion pulse; start here chains the next job
module systolic_feed_ctrl
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int K_MAX  = 64,
    parameter int PE_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    input  logic                         hold,
    input  logic                         abort,
    output logic                         sr_clear,
    output logic                         shift,
    output logic                         feed_valid,
    output logic [$clog2(K_MAX)-1:0]     k_idx,
    output logic                         acc_clear,
    output logic                         acc_en,
    output logic                         busy,
    output logic                         done
);

    localparam int KL_W = $clog2(K_MAX + 1);
    localparam int KI_W = $clog2(K_MAX);
    localparam int F    = flush_len(N, PE_LAT);
    localparam int FC_W = cnt_width(F);
    localparam logic [KL_W-1:0] K_MAX_V = KL_W'(K_MAX);
    localparam logic [FC_W-1:0] F_V     = FC_W'(F);

    ctrl_state_t     state;
    logic [KL_W-1:0] k_len_q;
    logic [KL_W-1:0] k_len_lim;
    logic [KL_W-1:0] k_count;
    logic [FC_W-1:0] flush_cnt_unused;
    logic            k_tc;
    logic            f_tc;
    logic            accept;
    logic            k_en;
    logic            f_en;

    assign k_len_lim = (k_len > K_MAX_V) ? K_MAX_V : k_len;
    assign accept    = ((state == IDLE) || (state == DONE)) && start;

    // k_count is the number of beats already issued. Beat 0 is issued on the
    // CLEAR -> FEED edge, so FEED never opens with an idle cycle.
    assign k_en = !abort && ((state == CLEAR) || ((state == FEED) && !hold && !k_tc));

    // The first flush shift is issued on the edge that leaves FEED.
    assign f_en = !abort && !hold &&
                  (((state == FEED) && k_tc) || ((state == FLUSH) && !f_tc));

    step_counter #(.W(KL_W)) u_k_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (k_en),
        .limit  (k_len_q),
        .count  (k_count),
        .tc     (k_tc)
    );

    // Only the terminal count of the flush counter drives decisions.
    step_counter #(.W(FC_W)) u_f_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (f_en),
        .limit  (F_V),
        .count  (flush_cnt_unused),
        .tc     (f_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k_len_q    <= '0;
            k_idx      <= '0;
            sr_clear   <= 1'b0;
            shift      <= 1'b0;
            feed_valid <= 1'b0;
            acc_clear  <= 1'b0;
            acc_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sr_clear   <= 1'b0;
            shift      <= 1'b0;
            feed_valid <= 1'b0;
            acc_clear  <= 1'b0;
            acc_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (k_len != '0) begin
                            k_len_q   <= k_len_lim;
                            state     <= CLEAR;
                            sr_clear  <= 1'b1;
                            acc_clear <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state    <= IDLE;
                        sr_clear <= 1'b1;
                    end else begin
                        state      <= FEED;
                        busy       <= 1'b1;
                        shift      <= 1'b1;
                        feed_valid <= 1'b1;
                        acc_en     <= 1'b1;
                        k_idx      <= KI_W'(k_count);
                    end
                end
                FEED: begin
                    if (abort) begin
                        state    <= IDLE;
                        sr_clear <= 1'b1;
                    end else if (k_tc) begin
                        state  <= FLUSH;
                        busy   <= 1'b1;
                        shift  <= !hold;
                        acc_en <= !hold;
                    end else begin
                        busy       <= 1'b1;
                        shift      <= !hold;
                        feed_valid <= !hold;
                        acc_en     <= !hold;
                        if (!hold) begin
                            k_idx <= KI_W'(k_count);
                        end
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state    <= IDLE;
                        sr_clear <= 1'b1;
                    end else if (f_tc) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        busy   <= 1'b1;
                        shift  <= !hold;
                        acc_en <= !hold;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] k_len;
    logic       hold;
    logic       abort;
    logic       sr_clear;
    logic       shift;
    logic       feed_valid;
    logic [5:0] k_idx;
    logic       acc_clear;
    logic       acc_en;
    logic       busy;
    logic       done;

    systolic_feed_ctrl #(.N(4), .K_MAX(64), .PE_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .hold       (hold),
        .abort      (abort),
        .sr_clear   (sr_clear),
        .shift      (shift),
        .feed_valid (feed_valid),
        .k_idx      (k_idx),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Output vector: {busy, done, sr_clear, acc_clear, shift, feed_valid, acc_en, k_idx}
    typedef struct {
        logic [12:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [12:0] dut_vec;

    assign dut_vec = {busy, done, sr_clear, acc_clear, shift, feed_valid, acc_en, k_idx};

    function automatic logic [12:0] mk(input bit b, input bit d, input bit sr, input bit ac,
                                       input bit sh, input bit fv, input bit ae, input int k);
        return {b, d, sr, ac, sh, fv, ae, 6'(k)};
    endfunction

    function automatic logic [12:0] e_idle(input int k);  return mk(0,0,0,0,0,0,0,k); endfunction
    function automatic logic [12:0] e_clr(input int k);   return mk(1,0,1,1,0,0,0,k); endfunction
    function automatic logic [12:0] e_feed(input int k);  return mk(1,0,0,0,1,1,1,k); endfunction
    function automatic logic [12:0] e_stall(input int k); return mk(1,0,0,0,0,0,0,k); endfunction
    function automatic logic [12:0] e_flush(input int k); return mk(1,0,0,0,1,0,1,k); endfunction
    function automatic logic [12:0] e_done(input int k);  return mk(0,1,0,0,0,0,0,k); endfunction
    function automatic logic [12:0] e_abort(input int k); return mk(0,0,1,0,0,0,0,k); endfunction

    // One clock cycle: drive this cycle's inputs and, if chk, queue the
    // outputs this cycle must show (produced by the previous edge).
    task automatic cyc(input logic st, input int kl, input logic hd, input logic ab,
                       input logic rs, input logic [12:0] e, input string nm, input bit chk);
        @(posedge clk);
        #1;
        start = st;
        k_len = 7'(kl);
        hold  = hd;
        abort = ab;
        reset = rs;
        if (chk) q.push_back('{e, nm});
    endtask

    task automatic flush_n(input int n, input int k, input string nm);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, e_flush(k), nm, 1);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_tests++;
            if (dut_vec !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s at %0t: got %b required %b (busy,done,sr_clr,acc_clr,shift,fv,acc_en,k_idx)",
                         mon_e.name, $time, dut_vec, mon_e.v);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        k_len = '0;
        hold  = 1'b0;
        abort = 1'b0;

        // Reset and idle
        cyc(0, 0, 0, 0, 1, e_idle(0), "reset0", 0);
        cyc(0, 0, 0, 0, 1, e_idle(0), "reset", 1);
        cyc(0, 0, 0, 0, 1, e_idle(0), "reset", 1);
        for (int i = 0; i < 4; i++) cyc(0, 5, 0, 0, 0, e_idle(0), "idle", 1);

        // Nominal k_len=3
        cyc(1, 3, 0, 0, 0, e_idle(0), "nom_c0", 1);
        cyc(0, 0, 0, 0, 0, e_clr(0),  "nom_clear", 1);
        cyc(0, 0, 0, 0, 0, e_feed(0), "nom_feed0", 1);
        cyc(0, 0, 0, 0, 0, e_feed(1), "nom_feed1", 1);
        cyc(0, 0, 0, 0, 0, e_feed(2), "nom_feed2", 1);
        flush_n(7, 2, "nom_flush");
        cyc(0, 0, 0, 0, 0, e_done(2), "nom_done", 1);
        cyc(0, 0, 0, 0, 0, e_idle(2), "nom_idle", 1);

        // Stall: hold driven in cycles 3 and 7
        cyc(1, 3, 0, 0, 0, e_idle(2),  "stl_c0", 1);
        cyc(0, 0, 0, 0, 0, e_clr(2),   "stl_clear", 1);
        cyc(0, 0, 0, 0, 0, e_feed(0),  "stl_feed0", 1);
        cyc(0, 0, 1, 0, 0, e_feed(1),  "stl_feed1", 1);
        cyc(0, 0, 0, 0, 0, e_stall(1), "stl_feed_held", 1);
        cyc(0, 0, 0, 0, 0, e_feed(2),  "stl_feed2", 1);
        cyc(0, 0, 0, 0, 0, e_flush(2), "stl_flush", 1);
        cyc(0, 0, 1, 0, 0, e_flush(2), "stl_flush", 1);
        cyc(0, 0, 0, 0, 0, e_stall(2), "stl_flush_held", 1);
        flush_n(5, 2, "stl_flush");
        cyc(0, 0, 0, 0, 0, e_done(2), "stl_done", 1);
        cyc(0, 0, 0, 0, 0, e_idle(2), "stl_idle", 1);

        // k_len=0: immediate done, no clear/shift/busy
        cyc(1, 0, 0, 0, 0, e_idle(2), "k0_c0", 1);
        cyc(0, 0, 0, 0, 0, e_done(2), "k0_done", 1);
        cyc(0, 0, 0, 0, 0, e_idle(2), "k0_idle", 1);

        // Abort in FEED, then restart (abort with start in IDLE is ignored)
        cyc(1, 3, 0, 0, 0, e_idle(2),  "abt_c0", 1);
        cyc(0, 0, 0, 0, 0, e_clr(2),   "abt_clear", 1);
        cyc(0, 0, 0, 0, 0, e_feed(0),  "abt_feed0", 1);
        cyc(0, 0, 0, 1, 0, e_feed(1),  "abt_feed1", 1);
        cyc(0, 0, 0, 0, 0, e_abort(1), "abt_srclear", 1);
        cyc(1, 2, 0, 1, 0, e_idle(1),  "abt_idle", 1);
        cyc(0, 0, 0, 0, 0, e_clr(1),   "abt2_clear", 1);
        cyc(0, 0, 0, 0, 0, e_feed(0),  "abt2_feed0", 1);
        cyc(0, 0, 0, 0, 0, e_feed(1),  "abt2_feed1", 1);
        flush_n(7, 1, "abt2_flush");
        cyc(0, 0, 0, 0, 0, e_done(1), "abt2_done", 1);
        cyc(0, 0, 0, 0, 0, e_idle(1), "abt2_idle", 1);

        // Back-to-back, start while busy ignored, reset in FLUSH
        cyc(1, 1, 0, 0, 0, e_idle(1),  "b2b_c0", 1);
        cyc(1, 5, 0, 0, 0, e_clr(1),   "b2b_clear", 1);
        cyc(1, 5, 0, 0, 0, e_feed(0),  "b2b_feed0", 1);
        flush_n(7, 0, "b2b_flush");
        cyc(1, 2, 0, 0, 0, e_done(0),  "b2b_done", 1);
        cyc(0, 0, 0, 0, 0, e_clr(0),   "b2b2_clear", 1);
        cyc(0, 0, 0, 0, 0, e_feed(0),  "b2b2_feed0", 1);
        cyc(0, 0, 0, 0, 0, e_feed(1),  "b2b2_feed1", 1);
        cyc(0, 0, 0, 0, 0, e_flush(1), "b2b2_flush", 1);
        cyc(0, 0, 0, 0, 0, e_flush(1), "b2b2_flush", 1);
        cyc(0, 0, 0, 0, 1, e_flush(1), "b2b2_flush", 1);
        cyc(0, 0, 0, 0, 0, e_idle(0),  "rst_in_flush", 1);
        cyc(0, 0, 0, 0, 0, e_idle(0),  "rst_idle", 1);

        // k_len above K_MAX clamps to 64 beats
        cyc(1, 100, 0, 0, 0, e_idle(0), "clamp_c0", 1);
        cyc(0, 0, 0, 0, 0, e_clr(0), "clamp_clear", 1);
        for (int i = 0; i < 64; i++) cyc(0, 0, 0, 0, 0, e_feed(i), "clamp_feed", 1);
        flush_n(7, 63, "clamp_flush");
        cyc(0, 0, 0, 0, 0, e_done(63), "clamp_done", 1);
        cyc(0, 0, 0, 0, 0, e_idle(63), "clamp_idle", 1);

        repeat (3) @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
